// File: rtl/fx2_host_model.sv
// fx2_host_model
//   Cycle-level model of the host side of an FX2 slave-FIFO interface.
//   A bench stages command bytes into EP2 (OUT), commits them for the FPGA
//   to read, and sinks bytes the FPGA writes into EP6 (IN).
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   ifclk           FX2 interface clock (pass-through of clk)
//   fd              FX2 data bus; driven with the EP2 head byte when selected
//   slrd/slwr/sloe  read strobe, write strobe, output enable (active low)
//   fifoadr         endpoint select: 00 = EP2, 10 = EP6
//   pktend          packet end (active low)
//   flags           [0] EP2 empty_n, [1] EP6 full_n, [2] EP6 empty_n
//   cmd_data/cmd_wr stage one command byte
//   cmd_commit      expose all staged bytes to the FPGA
//   cmd_sent        one-cycle pulse once every committed byte has been read
//   cmd_overflow    sticky; a staged byte was dropped
//   in_ready        drain one EP6 byte per cycle
//   in_data/in_valid last captured EP6 byte and its update pulse
//   in_pkt_count    count of EP6 pktend events (wraps)
module fx2_host_model #(
   parameter int unsigned OUT_DEPTH = 64,
   parameter int unsigned IN_DEPTH  = 512
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ifclk,
   inout  wire  [7:0]  fd,
   input  logic        slrd,
   input  logic        slwr,
   input  logic        sloe,
   input  logic [1:0]  fifoadr,
   input  logic        pktend,
   output logic [2:0]  flags,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_wr,
   input  logic        cmd_commit,
   output logic        cmd_sent,
   output logic        cmd_overflow,
   input  logic        in_ready,
   output logic [7:0]  in_data,
   output logic        in_valid,
   output logic [15:0] in_pkt_count
);

   localparam int unsigned OA = $clog2(OUT_DEPTH);
   localparam int unsigned IA = $clog2(IN_DEPTH);
   localparam logic [OA:0] EP2_FULL = (OA+1)'(OUT_DEPTH);
   localparam logic [IA:0] EP6_FULL = (IA+1)'(IN_DEPTH);

   logic [7:0]  ep2_mem [OUT_DEPTH];
   logic [OA:0] wr_ptr, cm_ptr, rd_ptr;
   logic [OA:0] wr_next, rd_next, cm_next, vis_count;
   logic        outstanding;
   logic        ep2_sel, ep6_sel;
   logic        stage_ok, rd_ok;
   logic [IA:0] ep6_count;
   logic        ep6_wr_ok, ep6_drain;

   assign ifclk = clk;

   always_comb begin
      ep2_sel   = (fifoadr == 2'b00);
      ep6_sel   = (fifoadr == 2'b10);
      vis_count = cm_ptr - rd_ptr;
      // Staging capacity counts both staged and committed-but-unread bytes.
      stage_ok  = cmd_wr && ((wr_ptr - rd_ptr) != EP2_FULL);
      rd_ok     = !slrd && ep2_sel && (vis_count != '0);
      wr_next   = wr_ptr + {{OA{1'b0}}, stage_ok};
      rd_next   = rd_ptr + {{OA{1'b0}}, rd_ok};
      // Commit snapshots the post-write pointer so a same-cycle byte is included.
      cm_next   = cmd_commit ? wr_next : cm_ptr;
      ep6_wr_ok = !slwr && ep6_sel && (ep6_count != EP6_FULL);
      ep6_drain = in_ready && (ep6_count != '0);
   end

   assign flags = {ep6_count != '0, ep6_count != EP6_FULL, vis_count != '0};

   // First-word fall-through: the head byte is on the bus before the strobe.
   assign fd = (!sloe && ep2_sel) ? ep2_mem[rd_ptr[OA-1:0]] : 8'hzz;

   always_ff @(posedge clk) begin
      if (stage_ok) begin
         ep2_mem[wr_ptr[OA-1:0]] <= cmd_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         cm_ptr       <= '0;
         rd_ptr       <= '0;
         outstanding  <= 1'b0;
         cmd_sent     <= 1'b0;
         cmd_overflow <= 1'b0;
         ep6_count    <= '0;
         in_data      <= '0;
         in_valid     <= 1'b0;
         in_pkt_count <= '0;
      end else begin
         wr_ptr <= wr_next;
         cm_ptr <= cm_next;
         rd_ptr <= rd_next;
         if (cmd_wr && !stage_ok) begin
            cmd_overflow <= 1'b1;
         end
         // A newly committed batch always leaves the visible count nonzero,
         // so setting and clearing outstanding can never collide.
         if (outstanding && (cm_next == rd_next)) begin
            cmd_sent    <= 1'b1;
            outstanding <= 1'b0;
         end else begin
            cmd_sent <= 1'b0;
            if (cmd_commit && (wr_next != cm_ptr)) begin
               outstanding <= 1'b1;
            end
         end
         ep6_count <= ep6_count + (IA+1)'(ep6_wr_ok) - (IA+1)'(ep6_drain);
         in_valid  <= ep6_wr_ok;
         if (ep6_wr_ok) begin
            in_data <= fd;
         end
         if (!pktend && ep6_sel) begin
            in_pkt_count <= in_pkt_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fx2_host_model.sv
// tb_fx2_host_model
//   Scoreboard bench for fx2_host_model. Stimulus updates a queue-based
//   reference model and pushes the expected visible state for every cycle;
//   a monitor on the falling edge pops and compares.
module tb_fx2_host_model;

   localparam int unsigned OUT_DEPTH = 64;
   localparam int unsigned IN_DEPTH  = 512;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, slrd, slwr, sloe, pktend, cmd_wr, cmd_commit, in_ready;
   logic [1:0]  fifoadr;
   logic [7:0]  cmd_data;
   logic        ifclk, cmd_sent, cmd_overflow, in_valid;
   logic [2:0]  flags;
   logic [7:0]  in_data;
   logic [15:0] in_pkt_count;
   wire  [7:0]  fd;
   logic        fd_en;
   logic [7:0]  fd_drv;

   assign fd = fd_en ? fd_drv : 8'hzz;

   fx2_host_model #(.OUT_DEPTH(OUT_DEPTH), .IN_DEPTH(IN_DEPTH)) dut (
      .clk(clk), .reset(reset), .ifclk(ifclk), .fd(fd),
      .slrd(slrd), .slwr(slwr), .sloe(sloe), .fifoadr(fifoadr), .pktend(pktend),
      .flags(flags), .cmd_data(cmd_data), .cmd_wr(cmd_wr), .cmd_commit(cmd_commit),
      .cmd_sent(cmd_sent), .cmd_overflow(cmd_overflow), .in_ready(in_ready),
      .in_data(in_data), .in_valid(in_valid), .in_pkt_count(in_pkt_count)
   );

   // inputs for the next cycle
   logic       n_reset, n_wr, n_commit, n_slrd, n_slwr, n_sloe, n_pktend, n_ready;
   logic [1:0] n_fa;
   logic [7:0] n_cmd, n_fd;

   // reference model: state as seen after the latest clock edge
   logic [7:0]  m_stage[$];
   logic [7:0]  m_vis[$];
   bit          m_out, m_sent, m_ovf, m_valid;
   int unsigned m_cnt;
   logic [15:0] m_pkt;
   logic [7:0]  m_data;

   typedef struct packed {
      logic [2:0]  flags;
      logic        sent;
      logic        ovf;
      logic        valid;
      logic [7:0]  data;
      logic [15:0] pkt;
      logic        fd_chk;
      logic [7:0]  fd_exp;
   } snap_t;

   snap_t      snap_q[$];
   logic [7:0] exp_in_q[$];
   int         checks = 0;
   int         failures = 0;

   task automatic model_reset();
      m_stage.delete();
      m_vis.delete();
      m_out = 0; m_sent = 0; m_ovf = 0; m_valid = 0;
      m_cnt = 0; m_pkt = '0; m_data = '0;
   endtask

   task automatic model_step();
      int unsigned held;
      bit rd, acc, drn;
      held = m_stage.size() + m_vis.size();
      rd = !n_slrd && (n_fa == 2'b00) && (m_vis.size() > 0);
      if (rd) void'(m_vis.pop_front());
      if (n_wr) begin
         if (held == OUT_DEPTH) m_ovf = 1;
         else m_stage.push_back(n_cmd);
      end
      if (n_commit && m_stage.size() > 0) begin
         while (m_stage.size() > 0) m_vis.push_back(m_stage.pop_front());
         m_out = 1;
      end
      if (m_out && m_vis.size() == 0) begin
         m_sent = 1;
         m_out = 0;
      end else begin
         m_sent = 0;
      end
      acc = !n_slwr && (n_fa == 2'b10) && (m_cnt < IN_DEPTH);
      drn = n_ready && (m_cnt > 0);
      if (acc) begin
         m_data = n_fd;
         exp_in_q.push_back(n_fd);
         m_cnt++;
      end
      if (drn) m_cnt--;
      m_valid = acc;
      if (!n_pktend && n_fa == 2'b10) m_pkt = m_pkt + 16'd1;
   endtask

   task automatic idle();
      n_reset = 0; n_wr = 0; n_commit = 0; n_slrd = 1; n_slwr = 1; n_sloe = 1;
      n_pktend = 1; n_ready = 0; n_fa = 2'b01; n_cmd = '0; n_fd = 8'($urandom);
   endtask

   task automatic cycle();
      snap_t s;
      @(posedge clk);
      #1;
      if (n_reset) begin
         model_reset();
         exp_in_q.delete();
      end
      s.flags  = {m_cnt != 0, m_cnt != IN_DEPTH, m_vis.size() != 0};
      s.sent   = m_sent;
      s.ovf    = m_ovf;
      s.valid  = m_valid;
      s.data   = m_data;
      s.pkt    = m_pkt;
      s.fd_chk = !n_sloe && (n_fa == 2'b00) && (m_vis.size() != 0);
      s.fd_exp = (m_vis.size() != 0) ? m_vis[0] : 8'h00;
      snap_q.push_back(s);
      reset = n_reset; cmd_wr = n_wr; cmd_data = n_cmd; cmd_commit = n_commit;
      slrd = n_slrd; slwr = n_slwr; sloe = n_sloe; pktend = n_pktend;
      in_ready = n_ready; fifoadr = n_fa;
      fd_drv = n_fd;
      fd_en = !(!n_sloe && n_fa == 2'b00);
      if (!n_reset) model_step();
   endtask

   task automatic do_reset();
      idle(); n_reset = 1; cycle(); cycle();
      idle(); cycle();
   endtask

   task automatic stage(input logic [7:0] b, input bit commit);
      idle(); n_wr = 1; n_cmd = b; n_commit = commit; cycle();
   endtask

   task automatic commit_only();
      idle(); n_commit = 1; cycle();
   endtask

   task automatic ep2_read();
      idle(); n_sloe = 0; n_fa = 2'b00; n_slrd = 0; cycle();
   endtask

   task automatic ep6_write(input logic [7:0] b, input bit ready);
      idle(); n_fa = 2'b10; n_slwr = 0; n_fd = b; n_ready = ready; cycle();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         idle(); cycle();
      end
   endtask

   // monitor
   snap_t       ms;
   logic [29:0] act, req;
   logic [7:0]  ein;

   always @(negedge clk) begin
      if (snap_q.size() > 0) begin
         ms  = snap_q.pop_front();
         act = {flags, cmd_sent, cmd_overflow, in_valid, in_data, in_pkt_count};
         req = {ms.flags, ms.sent, ms.ovf, ms.valid, ms.data, ms.pkt};
         checks++;
         if (act !== req) begin
            failures++;
            $display("FAIL status t=%0t actual flags=%b sent=%b ovf=%b valid=%b data=%h pkt=%0d required flags=%b sent=%b ovf=%b valid=%b data=%h pkt=%0d",
                     $time, flags, cmd_sent, cmd_overflow, in_valid, in_data, in_pkt_count,
                     ms.flags, ms.sent, ms.ovf, ms.valid, ms.data, ms.pkt);
         end
         if (ms.fd_chk) begin
            checks++;
            if (fd !== ms.fd_exp) begin
               failures++;
               $display("FAIL ep2_fd t=%0t actual=%h required=%h", $time, fd, ms.fd_exp);
            end
         end
      end
      if (in_valid === 1'b1) begin
         checks++;
         if (exp_in_q.size() == 0) begin
            failures++;
            $display("FAIL ep6_in_valid t=%0t actual=pulse required=none", $time);
         end else begin
            ein = exp_in_q.pop_front();
            if (in_data !== ein) begin
               failures++;
               $display("FAIL ep6_in_data t=%0t actual=%h required=%h", $time, in_data, ein);
            end
         end
      end
   end

   initial begin
      logic [7:0] cmd8 [8];
      cmd8 = '{8'hAA, 8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02};
      reset = 1; cmd_wr = 0; cmd_data = '0; cmd_commit = 0; slrd = 1; slwr = 1;
      sloe = 1; pktend = 1; in_ready = 0; fifoadr = 2'b01; fd_en = 1; fd_drv = '0;
      model_reset();
      do_reset();

      // reset with committed bytes pending
      for (int i = 0; i < 3; i++) stage(8'(8'h10 + i), i == 2);
      idle_cycles(1);
      idle(); n_reset = 1; cycle(); cycle();
      ep2_read(); ep2_read();
      idle_cycles(2);

      // command staging, commit, in-order read, single cmd_sent
      for (int i = 0; i < 8; i++) stage(cmd8[i], 0);
      commit_only();
      for (int i = 0; i < 8; i++) ep2_read();
      idle_cycles(3);

      // empty commit, then overlapping commits
      commit_only();
      idle_cycles(2);
      for (int i = 0; i < 3; i++) stage(8'($urandom), i == 2);
      ep2_read();
      for (int i = 0; i < 4; i++) stage(8'($urandom), i == 3);
      for (int i = 0; i < 7; i++) ep2_read();
      idle_cycles(3);

      // overflow: 65 staged into a 64-byte endpoint
      for (int i = 0; i < OUT_DEPTH + 1; i++) stage(8'(i), 0);
      commit_only();
      for (int i = 0; i < OUT_DEPTH + 1; i++) ep2_read();
      idle_cycles(2);
      do_reset();

      // EP6 fill to full, rejected write, then drain
      for (int i = 0; i < IN_DEPTH + 1; i++) ep6_write(8'($urandom), 0);
      for (int i = 0; i < IN_DEPTH + 2; i++) begin
         idle(); n_ready = 1; cycle();
      end

      // pktend on EP6 and on EP2 select
      ep6_write(8'h5A, 0);
      idle(); n_fa = 2'b10; n_pktend = 0; cycle();
      idle(); n_fa = 2'b00; n_pktend = 0; cycle();
      idle_cycles(2);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         idle();
         n_wr     = ($urandom_range(0, 2) == 0);
         n_cmd    = 8'($urandom);
         n_commit = ($urandom_range(0, 9) == 0);
         n_fa     = 2'($urandom_range(0, 3));
         n_slrd   = 1'($urandom_range(0, 1));
         n_slwr   = 1'($urandom_range(0, 1));
         n_sloe   = 1'($urandom_range(0, 1));
         n_pktend = ($urandom_range(0, 7) != 0);
         n_ready  = ($urandom_range(0, 3) == 0);
         n_reset  = ($urandom_range(0, 999) == 0);
         cycle();
      end
      idle_cycles(3);

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (snap_q.size() != 0) begin
         failures++;
         $display("FAIL status_drain actual=%0d required=0", snap_q.size());
      end
      checks++;
      if (exp_in_q.size() != 0) begin
         failures++;
         $display("FAIL ep6_missing_valid actual=%0d required=0", exp_in_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fx2_host_model.md
Name: fx2_host_model

Overview:
Synthesizable cycle-level model of the host side of an FX2 slave-FIFO interface, used in benches for the timetag FPGA top level.
- A bench stages command bytes, then commits them into the OUT endpoint (EP2) for the FPGA to read.
- The block sinks bytes the FPGA writes to the IN endpoint (EP6).
- The block drives the FX2 interface clock and flags.
- It reports when a committed command has been fully consumed.

Parameters:
OUT_DEPTH, 64, EP2 capacity in bytes (staged plus committed); power of two.
IN_DEPTH, 512, EP6 capacity in bytes; power of two.

Ports:
clk  input  1  single system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
ifclk  output  1  FX2 interface clock; equals clk (combinational pass-through).
fd  inout  8  FX2 data bus.
slrd  input  1  read strobe, active low.
slwr  input  1  write strobe, active low.
sloe  input  1  output enable, active low.
fifoadr  input  2  endpoint select: 00 = EP2 (OUT), 10 = EP6 (IN); 01 and 11 select nothing.
pktend  input  1  packet end, active low.
flags  output  3  [0] EP2 empty (active low), [1] EP6 full (active low), [2] EP6 empty (active low).
cmd_data  input  8  command byte to stage.
cmd_wr  input  1  stage cmd_data this cycle.
cmd_commit  input  1  make all staged bytes visible to the FPGA.
cmd_sent  output  1  one-cycle pulse when all committed bytes have been read.
cmd_overflow  output  1  sticky; set when a staged byte is dropped.
in_ready  input  1  host drains one EP6 byte per cycle while high.
in_data  output  8  last byte captured from EP6 writes.
in_valid  output  1  one-cycle pulse when in_data updates.
in_pkt_count  output  16  number of pktend events on EP6; wraps.

Behaviour:
- Reset, asynchronous:
  - All pointers and counters are 0; cmd_sent, in_valid and cmd_overflow are 0; in_data is 0.
  - flags = 3'b010: EP2 empty, EP6 not full, EP6 empty.
- EP2 storage is a circular buffer with three pointers: wr_ptr (staged), cm_ptr (committed) and rd_ptr. Each pointer is one bit wider than the address.
- Staging: on each clk edge with cmd_wr = 1, cmd_data is written at wr_ptr and wr_ptr increments.
  - If wr_ptr − rd_ptr == OUT_DEPTH, the byte is dropped and cmd_overflow is set. It stays set until reset.
- Commit: on a clk edge with cmd_commit = 1, cm_ptr takes the post-write value of wr_ptr. A byte staged in the same cycle is therefore included.
  - If anything was newly committed, the outstanding flag is set.
  - A commit with nothing staged has no effect.
- Visible EP2 count is cm_ptr − rd_ptr. flags[0] = 0 when this count is 0; it is combinational from the registered pointers.
- fd drive: the block drives fd with buf[rd_ptr] (first-word fall-through) only when sloe = 0 and fifoadr = 00. Otherwise fd is high-Z.
- EP2 read: on a clk edge with slrd = 0, fifoadr = 00 and the visible count nonzero, rd_ptr increments. A read from an empty EP2 is ignored.
- cmd_sent: pulses high for exactly the one cycle after the edge on which the visible count becomes 0 while outstanding = 1. The same edge clears outstanding.
  - Several commits made before draining produce a single pulse.
- EP6 write: on a clk edge with slwr = 0, fifoadr = 10 and EP6 not full:
  - in_data takes fd, in_valid pulses, and the EP6 count increments.
  - A write while EP6 is full is discarded, with no in_valid.
- EP6 drain: on each edge with in_ready = 1 and count > 0, the count decrements.
  - A write and a drain on the same edge leave the count unchanged.
  - When the count equals IN_DEPTH, a same-edge write is rejected even if a drain occurs.
- EP6 flags: flags[1] = 0 when count == IN_DEPTH; flags[2] = 0 when count == 0.
- pktend: on an edge with pktend = 0 and fifoadr = 10, in_pkt_count increments, wrapping modulo 2^16.
- Strobes with fifoadr 01 or 11 are ignored.
- A simultaneous slrd and slwr is legal; each is evaluated against its own fifoadr condition. Since fifoadr can select only one endpoint, at most one of them acts.

Test Plan:
- Reset mid-operation: with 3 bytes committed, assert reset → flags = 3'b010, cmd_sent = 0, and a later read finds EP2 empty.
- Stage AA 05 04 00 00 00 40 02 on 8 consecutive cycles, then commit:
  - before the commit, flags[0] stays 0;
  - after the commit, flags[0] = 1 and fd shows AA with sloe = 0 and fifoadr = 00;
  - 8 reads return bytes in order, then flags[0] = 0 and cmd_sent pulses exactly once, one cycle later.
- Commit with no staged bytes → no cmd_sent. Stage 4 bytes while 2 are still unread, commit, drain all → a single cmd_sent.
- Stage 65 bytes with OUT_DEPTH = 64 → cmd_overflow = 1; after commit, 64 bytes are readable.
- With in_ready = 0, write 512 bytes to fifoadr 10:
  - flags[1] = 0 and a 513th write produces no in_valid;
  - raise in_ready → flags[1] = 1 next cycle, and flags[2] = 0 after 512 cycles.
- Write 0x5A, then pulse pktend with fifoadr = 10 → in_data = 5A, in_valid pulses once, in_pkt_count = 1. A pktend with fifoadr = 00 leaves in_pkt_count unchanged.
